gray_step_monitor: RTL and testbench
====================================

// Module: gray_step_monitor
// PURPOSE
//   Receive side of the Gray-counter interface. Samples an N-bit Gray bus
//   (e.g. the leds output of the counter system) through a synchronizer and
//   decodes it to binary. Classifies every change as a legal +1 step, a
//   legal -1 step, or an illegal jump. Keeps a saturating error count for
//   board-level checking of the counter and for driving status LEDs.
// PARAMETERS
//   N           8  Gray/binary bus width (N >= 2)
//   SYNC_STAGES 2  synchronizer flops on gray_in (>= 2)
//   ERR_W       8  width of the saturating error counter
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   gray_in    in   N      Gray-coded input, asynchronous to clk
//   clr_err    in   1      sync clear of err_cnt/err_sticky, 1-cycle pulse
//   bin_out    out  N      registered binary decode of synchronized gray_in
//   valid      out  1      1 once the reference value is captured after reset
//   step_up    out  1      1-cycle pulse: new value = previous + 1 (mod 2^N)
//   step_down  out  1      1-cycle pulse: new value = previous - 1 (mod 2^N)
//   jump_err   out  1      1-cycle pulse: value changed by other than +/-1
//   err_cnt    out  ERR_W  count of jump_err events, saturating
//   err_sticky out  1      set by any jump_err, held until clr_err
// BEHAVIOUR
// - Reset (rst=0, async): synchronizer flops, prev, bin_out and err_cnt go
//   to 0. valid, step_up, step_down, jump_err and err_sticky go to 0.
//   FSM goes to S_FILL.
// - Decode (combinational on the synchronizer output g):
//   b[N-1]=g[N-1]; b[i]=b[i+1]^g[i].
// - FSM states S_FILL, S_TRACK:
//   S_FILL: fill counter runs SYNC_STAGES cycles after reset release.
//     On the last cycle: prev<=b, bin_out<=b, valid<=1, go to S_TRACK.
//     No step or error pulses are produced in S_FILL.
//   S_TRACK, every cycle: bin_out<=b and prev<=b.
//     b==prev: no pulse.
//     b==prev+1 (mod 2^N): step_up=1 for 1 cycle.
//     b==prev-1 (mod 2^N): step_down=1 for 1 cycle.
//     any other value: jump_err=1 for 1 cycle;
//       err_cnt<=min(err_cnt+1, 2^ERR_W-1); err_sticky<=1.
//   step_up, step_down and jump_err are mutually exclusive.
// - Wrap-around: prev=2^N-1 -> b=0 is step_up.
//   prev=0 -> b=2^N-1 is step_down.
// - Latency: a gray_in change before edge k appears on the synchronizer
//   output after SYNC_STAGES edges. bin_out and the pulse update on the next
//   edge, so total latency is SYNC_STAGES+1 edges.
// - clr_err: err_cnt<=0 and err_sticky<=0 on the next edge.
//   If a jump occurs in the same cycle, the event wins:
//   err_cnt<=1, err_sticky<=1.
// - Multi-bit skew: a glitch through the synchronizer is reported as
//   jump_err. The block does not filter it; the source must change gray_in
//   at most one bit per SYNC_STAGES+1 cycles.
// - Reset mid-operation: immediate return to reset values. Tracking history
//   is lost; the error count is not preserved.
// TESTING
// 1. rst low 3 cycles, release, gray_in=8'h00 held
//    -> valid=1 at edge 3 after release; bin_out=0; no pulses.
// 2. Up sweep: gray of 0..255 then 0, one change every 4 cycles
//    -> 256 step_up pulses, each 3 edges after its change.
//    Wrap 8'h80 -> 8'h00 gives step_up with bin_out=0. err_cnt=0.
// 3. From gray 8'h07 (bin 5) drive 8'h06 (bin 4)
//    -> step_down pulse, bin_out=4, no jump_err.
// 4. From 8'h00 drive 8'h03 (bin 2)
//    -> jump_err pulse, err_cnt=1, err_sticky=1, bin_out=2.
// 5. 300 illegal jumps -> err_cnt saturates at 255.
//    clr_err alone -> err_cnt=0, sticky=0.
//    clr_err together with a jump -> err_cnt=1, sticky=1.
// 6. Assert rst mid-sweep -> all outputs 0 immediately. After release,
//    valid returns after SYNC_STAGES+1 edges with bin_out = current decode.

Source files
------------

// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - synchronize a Gray bus, decode to binary, classify +1/-1/jump steps
module gray_step_monitor #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     gray_in,
  input  logic             clr_err,
  output logic [N-1:0]     bin_out,
  output logic             valid,
  output logic             step_up,
  output logic             step_down,
  output logic             jump_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic {S_FILL, S_TRACK} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [N-1:0]     r_sync [SYNC_STAGES];
  logic [FW-1:0]    r_fill;
  logic [N-1:0]     r_prev;
  logic [N-1:0]     r_bin;
  logic             r_valid;
  logic             r_up;
  logic             r_down;
  logic             r_jump;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_sticky;

  logic [N-1:0]     w_sync_g;
  logic [N-1:0]     w_bin;
  logic             w_fill_done;
  logic             w_load;
  logic             w_up;
  logic             w_down;
  logic             w_jump;

  assign w_sync_g = r_sync[SYNC_STAGES-1];

  // Multi-flop synchronizer on the asynchronous Gray bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < N; i++) w_bin[i] = ^(w_sync_g >> i);
  end

  // Fill counter waits for the synchronizer to flush stale reset data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill <= '0;
    end else if (r_state == S_FILL && !w_fill_done) begin
      r_fill <= r_fill + FW'(1);
    end
  end

  assign w_fill_done = (r_state == S_FILL) && (r_fill == FW'(SYNC_STAGES));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FILL;
    else      r_state <= w_next_state;
  end

  // FSM next-state logic: one pass through fill, then track forever
  always_comb begin
    w_next_state = r_state;
    if (w_fill_done) w_next_state = S_TRACK;
  end

  // FSM outputs: step classification against the previous decode
  always_comb begin
    w_load = 1'b0;
    w_up   = 1'b0;
    w_down = 1'b0;
    w_jump = 1'b0;
    if (w_fill_done) begin
      w_load = 1'b1;
    end else if (r_state == S_TRACK) begin
      w_load = 1'b1;
      if (w_bin == r_prev + N'(1))      w_up   = 1'b1;
      else if (w_bin == r_prev - N'(1)) w_down = 1'b1;
      else if (w_bin != r_prev)         w_jump = 1'b1;
    end
  end

  // Registered decode, reference value and single-cycle step pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= '0;
      r_bin   <= '0;
      r_valid <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_jump  <= 1'b0;
    end else begin
      if (w_load) begin
        r_prev <= w_bin;
        r_bin  <= w_bin;
      end
      if (w_fill_done) r_valid <= 1'b1;
      r_up   <= w_up;
      r_down <= w_down;
      r_jump <= w_jump;
    end
  end

  // Saturating error count and sticky flag; a jump in the clear cycle wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
      r_sticky  <= 1'b0;
    end else if (w_jump) begin
      r_sticky <= 1'b1;
      if (clr_err)                   r_err_cnt <= ERR_W'(1);
      else if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end else if (clr_err) begin
      r_err_cnt <= '0;
      r_sticky  <= 1'b0;
    end
  end

  assign bin_out    = r_bin;
  assign valid      = r_valid;
  assign step_up    = r_up;
  assign step_down  = r_down;
  assign jump_err   = r_jump;
  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_sticky;

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb/tb_gray_step_monitor.sv - self-checking bench for gray_step_monitor
module tb_gray_step_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray_in;
  logic       clr_err;
  logic [7:0] bin_out;
  logic       valid;
  logic       step_up;
  logic       step_down;
  logic       jump_err;
  logic [7:0] err_cnt;
  logic       err_sticky;

  int n_pass  = 0;
  int n_total = 0;

  gray_step_monitor #(.N(8), .SYNC_STAGES(2), .ERR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .clr_err    (clr_err),
    .bin_out    (bin_out),
    .valid      (valid),
    .step_up    (step_up),
    .step_down  (step_down),
    .jump_err   (jump_err),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] g_from;
    logic [7:0] g_to;
    logic [7:0] exp_bin;
    logic       exp_up;
    logic       exp_down;
    logic       exp_jump;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [7:0] to_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outputs(input string name, input int b, input int v, input int up,
                               input int dn, input int jp, input int ec, input int st);
    check({name, ".bin_out"},    bin_out,    b);
    check({name, ".valid"},      valid,      v);
    check({name, ".step_up"},    step_up,    up);
    check({name, ".step_down"},  step_down,  dn);
    check({name, ".jump_err"},   jump_err,   jp);
    check({name, ".err_cnt"},    err_cnt,    ec);
    check({name, ".err_sticky"}, err_sticky, st);
  endtask

  initial begin
    int bad;
    int wrap_ok;

    vecs[0] = '{8'h07, 8'h06, 8'd4,   1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 8'h03, 8'd2,   1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'd1,   1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h80, 8'd255, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h00, 8'd0,   1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h06, 8'h06, 8'd4,   1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 8'h03, 8'd2,   1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h03, 8'h01, 8'd1,   1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h02, 8'h06, 8'd4,   1'b1, 1'b0, 1'b0};
    vecs[9] = '{8'h00, 8'hC0, 8'd128, 1'b0, 1'b0, 1'b1};

    // Reset and fill
    rst = 1'b0; gray_in = 8'h00; clr_err = 1'b0;
    edges(3);
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    edges(2);
    check("fill_valid_early", valid, 0);
    edges(1);
    check_outputs("fill_done", 0, 1, 0, 0, 0, 0, 0);

    // Up sweep through all 256 codes including the wrap
    bad = 0;
    wrap_ok = 0;
    for (int i = 1; i <= 256; i++) begin
      gray_in = to_gray(8'(i));
      edges(3);
      if (step_up !== 1'b1 || bin_out !== 8'(i) || jump_err !== 1'b0 || step_down !== 1'b0) begin
        if (bad == 0) $display("FAIL sweep_step_%0d: bin_out=%0d step_up=%0b expected bin %0d with step_up", i, bin_out, step_up, i % 256);
        bad++;
      end else if (i == 256) begin
        wrap_ok = 1;
      end
      edges(1);
      if (step_up !== 1'b0) bad++;
    end
    check("sweep_bad_steps", bad, 0);
    check("sweep_wrap_up", wrap_ok, 1);
    check("sweep_err_cnt", err_cnt, 0);

    // Table-driven single transitions
    for (int k = 0; k < 10; k++) begin
      gray_in = vecs[k].g_from;
      edges(4);
      clr_err = 1'b1;
      edges(1);
      clr_err = 1'b0;
      gray_in = vecs[k].g_to;
      edges(3);
      check($sformatf("vec%0d.bin_out", k),   bin_out,    vecs[k].exp_bin);
      check($sformatf("vec%0d.step_up", k),   step_up,    vecs[k].exp_up);
      check($sformatf("vec%0d.step_down", k), step_down,  vecs[k].exp_down);
      check($sformatf("vec%0d.jump_err", k),  jump_err,   vecs[k].exp_jump);
      check($sformatf("vec%0d.err_cnt", k),   err_cnt,    vecs[k].exp_jump ? 1 : 0);
      check($sformatf("vec%0d.sticky", k),    err_sticky, vecs[k].exp_jump);
      edges(1);
      check($sformatf("vec%0d.pulse_end", k), step_up | step_down | jump_err, 0);
    end

    // Saturation over 300 illegal jumps
    gray_in = 8'h00;
    edges(4);
    clr_err = 1'b1;
    edges(1);
    clr_err = 1'b0;
    for (int j = 0; j < 300; j++) begin
      gray_in = (j % 2 == 0) ? 8'h03 : 8'h00;
      edges(4);
    end
    check("sat_err_cnt", err_cnt, 255);
    check("sat_sticky", err_sticky, 1);

    // Clear alone
    clr_err = 1'b1;
    edges(1);
    clr_err = 1'b0;
    check("clr_err_cnt", err_cnt, 0);
    check("clr_sticky", err_sticky, 0);

    // Clear in the same cycle as a jump
    gray_in = 8'h03;
    edges(2);
    clr_err = 1'b1;
    edges(1);
    clr_err = 1'b0;
    check("clrjump_jump", jump_err, 1);
    check("clrjump_err_cnt", err_cnt, 1);
    check("clrjump_sticky", err_sticky, 1);

    // Reset mid-sweep
    gray_in = to_gray(8'd3);
    edges(3);
    check("pre_reset_up", step_up, 1);
    rst = 1'b0;
    #1;
    check_outputs("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    gray_in = to_gray(8'd37);
    edges(1);
    rst = 1'b1;
    edges(2);
    check("refill_valid_early", valid, 0);
    edges(1);
    check_outputs("refill_done", 37, 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
